// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and index/code width helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  // Never returns 0 so single-entry ranges still get a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return idx_width(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_fifo.sv
// Small synchronous FIFO for key codes; the head is presented combinationally and reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // When full, a push only lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column at a time, debounces a single key and queues its code.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_SCANS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ROWS-1:0]                    filas,
  output logic [COLS-1:0]                    columnas,
  output logic                               key_valid,
  input  logic                               key_ready,
  output logic [code_width(ROWS, COLS)-1:0]  key_code,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               key_held,
  output logic                               overflow,
  input  logic                               clr_ovf
);

  localparam int CODE_W = code_width(ROWS, COLS);
  localparam int COL_W  = idx_width(COLS);
  localparam int ROW_W  = idx_width(ROWS);
  localparam int DIV_W  = idx_width(SCAN_DIV);
  localparam int DEB_W  = idx_width(DEB_SCANS + 1);

  logic [ROWS-1:0]   filas_s1, filas_s2;
  logic [DIV_W-1:0]  scan_cnt;
  logic [COL_W-1:0]  col_q, col_d, next_col;
  logic [ROW_W-1:0]  row_q, row_d, low_row;
  logic [DEB_W-1:0]  deb_cnt, deb_d;
  scan_state_t       state_q, state_d;
  logic              sample_pt;
  logic              row_hit;
  logic              push;
  logic [CODE_W-1:0] push_code;
  logic              fifo_full;
  logic              pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      filas_s1 <= '0;
      filas_s2 <= '0;
      scan_cnt <= '0;
    end else begin
      filas_s1 <= filas;
      filas_s2 <= filas_s1;
      scan_cnt <= sample_pt ? '0 : scan_cnt + DIV_W'(1);
    end
  end

  assign sample_pt = (scan_cnt == DIV_W'(SCAN_DIV - 1));
  assign row_hit   = filas_s2[row_q];
  assign next_col  = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);

  // Descending walk so the lowest-index closed row is the one that sticks.
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (filas_s2[r]) low_row = ROW_W'(r);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      row_q   <= '0;
      deb_cnt <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      deb_cnt <= deb_d;
    end
  end

  // Everything moves only at sample points; the column stays frozen while a key is tracked.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    deb_d   = deb_cnt;
    push    = 1'b0;
    if (sample_pt) begin
      case (state_q)
        ST_SCAN: begin
          if (|filas_s2) begin
            row_d = low_row;
            if (DEB_SCANS == 1) begin
              push    = 1'b1;
              deb_d   = '0;
              state_d = ST_HELD;
            end else begin
              deb_d   = DEB_W'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = next_col;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_hit) begin
            deb_d   = '0;
            col_d   = next_col;
            state_d = ST_SCAN;
          end else if (deb_cnt == DEB_W'(DEB_SCANS - 1)) begin
            push    = 1'b1;
            deb_d   = '0;
            state_d = ST_HELD;
          end else begin
            deb_d = deb_cnt + DEB_W'(1);
          end
        end
        ST_HELD: begin
          if (!row_hit) begin
            if (DEB_SCANS == 1) begin
              deb_d   = '0;
              col_d   = next_col;
              state_d = ST_SCAN;
            end else begin
              deb_d   = DEB_W'(1);
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (row_hit) begin
            deb_d   = '0;
            state_d = ST_HELD;
          end else if (deb_cnt == DEB_W'(DEB_SCANS - 1)) begin
            deb_d   = '0;
            col_d   = next_col;
            state_d = ST_SCAN;
          end else begin
            deb_d = deb_cnt + DEB_W'(1);
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    columnas        = '0;
    columnas[col_q] = 1'b1;
  end

  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
  assign push_code = CODE_W'(int'(row_d) * COLS + int'(col_q));
  assign pop       = key_valid && key_ready;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_code),
    .dout  (key_code),
    .valid (key_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // A set in the same cycle as clr_ovf keeps the flag raised.
  always_ff @(posedge clk) begin
    if (!reset)                        overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
    else if (clr_ovf)                  overflow <= 1'b0;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows (sensed lines).
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns (driven lines).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven (>=4).
REQ-004 SHALL have parameter DEB_SCANS, default 3, consecutive equal samples required for press/release (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, key-code buffer entries (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port filas  input  ROWS  row sense lines, 1 = key closed in driven column, asynchronous.
REQ-009 SHALL have port columnas  output  COLS  one-hot column drive.
REQ-010 SHALL have port key_valid  output  1  FIFO head holds a key code.
REQ-011 SHALL have port key_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port key_code  output  $clog2(ROWS*COLS)  head entry, row*COLS+col.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 SHALL have port key_held  output  1  a debounced key is currently pressed.
REQ-015 SHALL have port overflow  output  1  sticky, a press was dropped.
REQ-016 SHALL have port clr_ovf  input  1  clears overflow.

Function
REQ-017 SHALL pass filas through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-018 SHALL count 0..SCAN_DIV-1 per column and sample rows at count SCAN_DIV-1 ("sample point").
REQ-019 SHALL, in SCAN only, advance columnas one position at each sample point, wrapping from COLS-1 to 0.
REQ-020 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-021 SHALL, in SCAN, at a sample point with any row high: latch the lowest-index high row and the current column, set debounce count to 1, enter DEBOUNCE, and freeze columnas.
REQ-022 SHALL, in DEBOUNCE, increment the count at each sample point while the latched row is high, and return to SCAN (count cleared, column advances) on a low sample.
REQ-023 SHALL, when the count reaches DEB_SCANS, push row*COLS+col into the FIFO and enter HELD; DEB_SCANS=1 pushes on the first sample.
REQ-024 SHALL, in HELD, enter RELEASE on a low sample of the latched row; rows other than the latched row are ignored.
REQ-025 SHALL, in RELEASE, return to SCAN after DEB_SCANS consecutive low samples; a high sample returns to HELD with no new push.
REQ-026 SHALL drive key_held high exactly in HELD and RELEASE.
REQ-027 SHALL assert key_valid the cycle after a push into an empty FIFO; key_code equals the head entry whenever key_valid is high.
REQ-028 SHALL pop on key_valid && key_ready; key_ready with an empty FIFO has no effect.
REQ-029 SHALL, on push while full without pop, drop the new code, keep contents, and set overflow.
REQ-030 SHALL, on simultaneous push and pop while full, perform both with no overflow.
REQ-031 SHALL let set win over clr_ovf when both occur in the same cycle.

Reset
REQ-032 SHALL, on a clk edge with reset low, set: columnas = one-hot column 0, state SCAN, scan and debounce counters 0, synchroniser 0, FIFO empty, key_valid 0, key_code 0, fifo_count 0, key_held 0, overflow 0.
REQ-033 SHALL discard an in-progress press and all buffered codes when reset is asserted mid-operation.

Structure
REQ-034 SHALL place the FSM state encoding and key-code width function in a shared package keypad_pkg.
REQ-035 SHALL implement buffering in one sub-module, sync_fifo, parameterised by width and depth.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEB_SCANS=2, FIFO_DEPTH=2)
REQ-036 SHALL verify reset release: columnas = 0001, then 0010 after 4 cycles, then back to 0001 after 16 cycles; key_valid = 0.
REQ-037 SHALL verify a press: filas[2] follows columnas[1] for 5 sample points; exactly one code, 9, is pushed; key_valid rises 1 cycle after the push; key_held = 1; columnas stays 0010 until the release is debounced.
REQ-038 SHALL verify bounce rejection: a row high for 1 sample point only gives no push and scanning resumes.
REQ-039 SHALL verify overflow: three distinct presses with key_ready = 0 give fifo_count = 2, overflow = 1, and the first two codes intact; clr_ovf clears overflow.
REQ-040 SHALL verify a full-FIFO push with key_ready = 1 in the same cycle: fifo_count stays 2, overflow stays 0.
REQ-041 SHALL verify reset asserted while in HELD: all outputs take their reset values on the next edge and the FIFO is empty.
